// File: rtl/product_acc_pkg.sv
// Shared types and width/limit helpers for the product accumulator.
// Saturation limits are only consumed when PRODUCT_ACC_SATURATE_EN is defined.
package product_acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_t;

   // Widest accumulator the limit helpers can describe.
   localparam int SAT_MAX_AW = 128;

   function automatic int calc_acc_width(input int bit_width, input int acc_guard);
      return 2 * bit_width + acc_guard;
   endfunction

   // Most positive aw-bit two's-complement value, zero-extended.
   function automatic logic [SAT_MAX_AW-1:0] sat_pos_limit(input int aw);
      logic [SAT_MAX_AW-1:0] v;
      v = '0;
      for (int i = 0; i < SAT_MAX_AW; i++) begin
         if (i < aw - 1) v[i] = 1'b1;
      end
      return v;
   endfunction

   // Most negative aw-bit two's-complement value, zero-extended.
   function automatic logic [SAT_MAX_AW-1:0] sat_neg_limit(input int aw);
      logic [SAT_MAX_AW-1:0] v;
      v = '0;
      for (int i = 0; i < SAT_MAX_AW; i++) begin
         if (i == aw - 1) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/acc_add_sat.sv
// Combinational AW-bit signed adder with overflow flag.
// With PRODUCT_ACC_SATURATE_EN defined the sum clamps instead of wrapping.
module acc_add_sat
   import product_acc_pkg::*;
#(
   parameter int AW = 40
) (
   input  logic [AW-1:0] a_i,
   input  logic [AW-1:0] b_i,
   output logic [AW-1:0] sum_o,
   output logic          ovf_o
);

   logic [AW-1:0] raw_sum;
   logic          ovf;

   assign raw_sum = a_i + b_i;
   // Overflow: operands agree in sign but the sum does not.
   assign ovf     = (a_i[AW-1] == b_i[AW-1]) && (raw_sum[AW-1] != a_i[AW-1]);
   assign ovf_o   = ovf;

`ifdef PRODUCT_ACC_SATURATE_EN
   localparam logic [SAT_MAX_AW-1:0] SAT_POS_FULL = sat_pos_limit(AW);
   localparam logic [SAT_MAX_AW-1:0] SAT_NEG_FULL = sat_neg_limit(AW);
   localparam logic [AW-1:0]         SAT_POS      = SAT_POS_FULL[AW-1:0];
   localparam logic [AW-1:0]         SAT_NEG      = SAT_NEG_FULL[AW-1:0];

   always_comb begin
      sum_o = raw_sum;
      if (ovf) sum_o = a_i[AW-1] ? SAT_NEG : SAT_POS;
   end
`else
   assign sum_o = raw_sum;
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums a job of len signed products into a guard-extended accumulator and
// presents the result on a valid/ready port. Build option: PRODUCT_ACC_SATURATE_EN.
module product_accumulator
   import product_acc_pkg::*;
#(
   parameter  int BIT_WIDTH = 16,
   parameter  int ACC_GUARD = 8,
   parameter  int LEN_WIDTH = 8,
   localparam int PW        = 2 * BIT_WIDTH,
   localparam int AW        = calc_acc_width(BIT_WIDTH, ACC_GUARD)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] len,
   input  logic                 prod_valid,
   input  logic [PW-1:0]        prod_data,
   output logic                 prod_ready,
   output logic                 acc_valid,
   output logic [AW-1:0]        acc_data,
   output logic                 acc_overflow,
   input  logic                 acc_ready,
   output logic                 busy
);

   acc_state_t           state_q, state_d;
   logic [AW-1:0]        acc_q, acc_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic                 ovf_q, ovf_d;

   logic [AW-1:0]        prod_ext;
   logic [AW-1:0]        add_sum;
   logic                 add_ovf;
   logic [LEN_WIDTH-1:0] cnt_inc;

   assign prod_ext = {{(AW-PW){prod_data[PW-1]}}, prod_data};
   assign cnt_inc  = cnt_q + LEN_WIDTH'(1);

   acc_add_sat #(
      .AW (AW)
   ) u_add (
      .a_i   (acc_q),
      .b_i   (prod_ext),
      .sum_o (add_sum),
      .ovf_o (add_ovf)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               len_d   = len;
               state_d = (len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (prod_valid) begin
               acc_d = add_sum;
               ovf_d = ovf_q | add_ovf;
               cnt_d = cnt_inc;
               if (cnt_inc == len_q) state_d = DONE;
            end
         end
         DONE: begin
            if (acc_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
      end
   end

   // Every output decodes registered state only.
   assign prod_ready   = (state_q == ACCUM);
   assign acc_valid    = (state_q == DONE);
   assign busy         = (state_q != IDLE);
   assign acc_data     = acc_q;
   assign acc_overflow = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator (AW=33 instance); expectations
// for the overflow jobs follow PRODUCT_ACC_SATURATE_EN.
module tb_product_accumulator;

   localparam int BW = 16;
   localparam int GD = 1;
   localparam int LW = 8;
   localparam int PW = 2 * BW;
   localparam int AW = PW + GD;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [LW-1:0] len;
   logic          prod_valid;
   logic [PW-1:0] prod_data;
   logic          prod_ready;
   logic          acc_valid;
   logic [AW-1:0] acc_data;
   logic          acc_overflow;
   logic          acc_ready;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   product_accumulator #(
      .BIT_WIDTH (BW),
      .ACC_GUARD (GD),
      .LEN_WIDTH (LW)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .len          (len),
      .prod_valid   (prod_valid),
      .prod_data    (prod_data),
      .prod_ready   (prod_ready),
      .acc_valid    (acc_valid),
      .acc_data     (acc_data),
      .acc_overflow (acc_overflow),
      .acc_ready    (acc_ready),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [LW-1:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
      check("start_busy", 64'(busy), 64'd1);
      check("start_prod_ready", 64'(prod_ready), (l != 0) ? 64'd1 : 64'd0);
   endtask

   task automatic send(input logic [PW-1:0] d, input int gap);
      prod_valid = 1'b0;
      repeat (gap) begin
         tick();
         check("gap_acc_valid", 64'(acc_valid), 64'd0);
      end
      check("beat_prod_ready", 64'(prod_ready), 64'd1);
      check("beat_acc_valid", 64'(acc_valid), 64'd0);
      prod_valid = 1'b1;
      prod_data  = d;
      tick();
      prod_valid = 1'b0;
   endtask

   task automatic finish_job(input string tag, input logic [63:0] exp_data, input logic exp_ovf);
      check({tag, "_acc_valid"}, 64'(acc_valid), 64'd1);
      check({tag, "_prod_ready"}, 64'(prod_ready), 64'd0);
      check({tag, "_acc_data"}, 64'(acc_data), exp_data);
      check({tag, "_acc_overflow"}, 64'(acc_overflow), 64'(exp_ovf));
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
      check({tag, "_idle_acc_valid"}, 64'(acc_valid), 64'd0);
      $display("job %s: acc_data=0x%0h acc_overflow=%0d", tag, acc_data, acc_overflow);
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      len        = '0;
      prod_valid = 1'b0;
      prod_data  = '0;
      acc_ready  = 1'b0;
      tick();
      tick();
      check("rst_prod_ready", 64'(prod_ready), 64'd0);
      check("rst_acc_valid", 64'(acc_valid), 64'd0);
      check("rst_acc_data", 64'(acc_data), 64'd0);
      check("rst_acc_overflow", 64'(acc_overflow), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      reset_n = 1'b1;
      tick();

      // Basic job: 3 - 5 + 100 - 2 = 96, beats back to back.
      do_start(8'd4);
      send(32'd3, 0);
      send(-32'sd5, 0);
      send(32'd100, 0);
      send(-32'sd2, 0);
      finish_job("basic", 64'd96, 1'b0);

      // Empty job goes straight to DONE with a zero result.
      do_start(8'd0);
      finish_job("empty", 64'd0, 1'b0);

      // Positive overflow at the 4th add: 4 * 2^30 exceeds 2^32-1.
      do_start(8'd4);
      repeat (4) send(32'h4000_0000, 0);
`ifdef PRODUCT_ACC_SATURATE_EN
      finish_job("ovf_pos", 64'h0_FFFF_FFFF, 1'b1);
`else
      finish_job("ovf_pos", 64'h1_0000_0000, 1'b1);
`endif

      // Negative overflow at the 3rd add, then +1 with the flag staying set.
      do_start(8'd4);
      repeat (3) send(32'h8000_0000, 0);
      send(32'd1, 0);
`ifdef PRODUCT_ACC_SATURATE_EN
      finish_job("ovf_neg", 64'h1_0000_0001, 1'b1);
`else
      finish_job("ovf_neg", 64'h0_8000_0001, 1'b1);
`endif

      // Stalls on both sides; a start during DONE must be dropped.
      do_start(8'd3);
      send(32'd10, 2);
      send(32'd20, 2);
      send(32'd30, 2);
      for (int i = 0; i < 5; i++) begin
         check("stall_acc_valid", 64'(acc_valid), 64'd1);
         check("stall_acc_data", 64'(acc_data), 64'd60);
         start = (i == 2);
         len   = 8'd7;
         tick();
         start = 1'b0;
      end
      finish_job("stall", 64'd60, 1'b0);
      tick();
      check("stall_no_queued_start", 64'(busy), 64'd0);

      // Reset in the middle of a job discards it.
      do_start(8'd5);
      send(32'd11, 0);
      send(32'd22, 0);
      check("mid_acc_data", 64'(acc_data), 64'd33);
      reset_n = 1'b0;
      tick();
      check("midrst_prod_ready", 64'(prod_ready), 64'd0);
      check("midrst_acc_valid", 64'(acc_valid), 64'd0);
      check("midrst_acc_data", 64'(acc_data), 64'd0);
      check("midrst_acc_overflow", 64'(acc_overflow), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      reset_n = 1'b1;
      tick();
      do_start(8'd1);
      send(-32'sd7, 0);
      finish_job("after_rst", 64'h1_FFFF_FFF9, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the registered Booth radix-4 multiplier output. Accepts a job of `len` signed products over a valid/ready stream and sums them into a guard-extended accumulator. It then presents the sum and a sticky overflow flag on a valid/ready result port. This is the accumulate half of the multiply-accumulate datapath.

## Interface
- `BIT_WIDTH`, 16: multiplier operand width; product width `PW = 2*BIT_WIDTH`.
- `ACC_GUARD`, 8: guard bits; accumulator width `AW = PW + ACC_GUARD`.
- `LEN_WIDTH`, 8: width of the job length field.
- `clk` in 1: clock clk.
- `reset_n` in 1: reset reset_n, synchronous, active-low.
- `start` in 1: job request; sampled only in IDLE.
- `len` in LEN_WIDTH: number of products in the job, captured on accepted `start`.
- `prod_valid` in 1: product beat valid.
- `prod_data` in PW: signed two's-complement product.
- `prod_ready` out 1: block accepts a product.
- `acc_valid` out 1: result valid.
- `acc_data` out AW: signed accumulated result.
- `acc_overflow` out 1: sticky signed overflow seen during the job.
- `acc_ready` in 1: result consumer ready.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM has three states: IDLE, ACCUM, DONE.
- **IDLE**
  - `prod_ready=0`, `acc_valid=0`.
  - `start=1`: clears the accumulator, clears the overflow flag, clears the beat counter, and latches `len`.
  - `len==0`: next state is DONE with result 0.
  - Otherwise the next state is ACCUM.
- **ACCUM**
  - `prod_ready=1`.
  - A beat transfers on `prod_valid & prod_ready`.
  - Each transfer: `acc <= acc + sign_extend(prod_data, AW)` and the counter increments.
  - The transfer that makes the counter equal to the latched `len` moves the FSM to DONE. The final add lands on the same edge.
  - Cycles with `prod_valid=0` hold all state. Gaps are unlimited.
- **DONE**
  - `acc_valid=1`.
  - `acc_data` and `acc_overflow` are held stable until `acc_ready=1`.
  - On that handshake edge the FSM returns to IDLE.
  - `acc_data` keeps its last value afterwards; it is meaningful only while `acc_valid=1`.
- `start` outside IDLE is ignored and not queued. A `start` in the same cycle as the DONE handshake is also ignored.
- **Overflow detection:** signed overflow of the AW-bit add, i.e. both operands have equal sign and the sum has a different sign. Once set, the flag stays set until the next accepted `start`.
- **Arithmetic:** all two's-complement. `prod_data` is sign-extended from bit PW-1. The counter is LEN_WIDTH bits and never wraps, because a job terminates at `len`.
- **Reset:** `reset_n=0` at any clock edge, including mid-ACCUM or DONE, forces:
  - IDLE;
  - `acc=0`, counter 0, `acc_overflow=0`;
  - all outputs 0: `prod_ready`, `acc_valid`, `acc_data`, `acc_overflow`, `busy`.
  - A partially accumulated job is discarded.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Throughput is one product per cycle in ACCUM.
- `prod_ready` rises the cycle after `start` is accepted.
- `acc_valid` rises the cycle after the last accepted beat. For `len==0`, it rises the cycle after `start`.
- Minimum job time, with `acc_ready` held high: `len + 2` cycles from the `start` edge to back in IDLE.
- `busy` asserts the cycle after accepted `start` and deasserts the cycle after the result handshake.

## Configuration
- Macro: `PRODUCT_ACC_SATURATE_EN`.
- **Defined:** on an overflowing add, the accumulator is clamped.
  - Positive overflow clamps to `2^(AW-1)-1`.
  - Negative overflow clamps to `-2^(AW-1)`.
  - Later adds continue from the clamped value.
- **Undefined:** the accumulator wraps modulo `2^AW`.
- `acc_overflow` behaves identically in both builds.

## Structure
- Package `product_acc_pkg` holds:
  - the state enum `acc_state_t` (IDLE, ACCUM, DONE);
  - the localparam function computing AW from BIT_WIDTH and ACC_GUARD;
  - the saturation limit constants.
- Sub-module `acc_add_sat` is the natural split. It is a combinational AW-bit signed adder producing the sum and an overflow output, and it contains the `PRODUCT_ACC_SATURATE_EN` clamp.
- The top level keeps the FSM, the counter and the registers.

## Test plan
1. **Basic job.** `len=4`; products 3, -5, 100, -2 with `prod_valid` held high.
   - `acc_data=96`, `acc_overflow=0`.
   - `acc_valid` high exactly one cycle after the 4th beat.
2. **Empty job.** `len=0`, `start` pulse.
   - `acc_valid=1` next cycle, `acc_data=0`, `prod_ready` never high.
3. **Stalls on both sides.** `len=3` with products 10, 20, 30 and 2-cycle `prod_valid` gaps; `acc_ready` low for 5 cycles.
   - `acc_data=60` stable throughout.
   - A `start` pulse during DONE is ignored.
4. **Overflow.** `ACC_GUARD=1` (AW=33); `len=4`; each product 0x40000000.
   - `acc_overflow=1` in both builds.
   - With `PRODUCT_ACC_SATURATE_EN`: `acc_data=0x0FFFFFFFF`.
   - Without it: `acc_data=0x100000000`.
5. **Reset mid-job.** `len=5`; assert `reset_n=0` after 2 beats.
   - Next cycle: all outputs 0, `busy=0`.
   - A new job with `len=1`, product -7, then yields `acc_data=-7`, `acc_overflow=0`.
